sfp_norm: RTL and testbench
===========================

SFP_NORM -- requirements
Module: sfp_norm

Interface
REQ-001 Parameter col, 8, number of psum lanes per row.
REQ-002 Parameter bw_psum, 20, signed width of one psum lane.
REQ-003 Parameter frac, 8, fraction bits of the normalized result.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in  input  bw_psum*col  psum row from psum memory; lane i is in[bw_psum*(i+1)-1 : bw_psum*i], two's complement.
REQ-007 in_valid  input  1  row on in is valid.
REQ-008 in_ready  output  1  block is in IDLE and accepts a row.
REQ-009 out  output  bw_psum*col  result row; lane i is zero-extended to bw_psum.
REQ-010 sum_out  output  bw_psum+4  unsigned sum of lane magnitudes of the current row.
REQ-011 out_valid  output  1  out and sum_out hold a complete result.
REQ-012 out_ready  input  1  consumer takes the result.

Function
REQ-013 The FSM SHALL have four states: IDLE, SUM, DIV, DONE.
- IDLE: in_ready=1.
- IDLE->SUM on in_valid&&in_ready; the row is registered on that edge.
REQ-014 SUM SHALL last exactly one cycle. It registers |x_i| for every lane and S = sum of |x_i| into sum_out. It then goes to DIV, or to DONE when normalization is compiled out.
REQ-015 Magnitude SHALL be unsigned bw_psum bits; |-2^(bw_psum-1)| = 2^(bw_psum-1) with no saturation. The sum SHALL be bw_psum+4 bits wide and cannot overflow.
REQ-016 DIV SHALL process lanes 0..col-1 in order. Each lane takes exactly frac+1 cycles, so DIV lasts col*(frac+1) cycles (72 at defaults).
REQ-017 Per lane, DIV SHALL compute q_i = floor(|x_i|*2^frac / S) as a frac+1-bit quotient using a restoring divider.
- Remainder r initialized to |x_i|.
- Each step: bit = (r>=S); r = (r - bit*S)<<1.
- Bits are produced MSB first.
REQ-018 When S==0, every q_i SHALL be 0 and DIV timing SHALL be unchanged.
REQ-019 DONE SHALL hold out_valid=1 with out and sum_out stable. DONE->IDLE on out_ready; out_valid is 0 the cycle after.
REQ-020 in_valid SHALL be ignored outside IDLE. A row presented with in_ready=0 is not captured.
REQ-021 out SHALL change only on entry to DONE; intermediate quotients are not visible on out.

Reset
REQ-022 Reset SHALL force IDLE on the next edge from any state, including mid-DIV. It discards the partial result.
REQ-023 After reset: out=0, sum_out=0, out_valid=0, in_ready=1, lane and step counters = 0.
REQ-024 Reset SHALL take priority over in_valid and out_ready on the same edge.

Configuration
REQ-025 Macro SFP_NORM_DIV_EN defined: behaviour as REQ-016..018.
REQ-026 SFP_NORM_DIV_EN undefined:
- The divider SHALL be removed.
- SUM goes directly to DONE.
- out lane i = |x_i|.
- Result latency from capture to out_valid = 2 cycles.

Structure
REQ-027 Package sfp_pkg SHALL hold:
- FSM state encoding;
- default col/bw_psum/frac constants;
- the derived sum width (bw_psum+4) and quotient width (frac+1).
REQ-028 The restoring divider SHALL be a sub-module, sfp_div_seq: start, dividend magnitude, divisor, busy/done, frac+1-bit quotient. It is instantiated once and reused per lane.

Verification
REQ-029 All lanes = +1 -> sum_out=8, every out lane=32, out_valid 74 cycles after the capture edge (defaults).
REQ-030 Lane0=-4, lane1=+4, others 0 -> sum_out=8, out lane0=128, lane1=128, others 0.
REQ-031 All lanes 0 -> sum_out=0, all out lanes 0, same 74-cycle latency.
REQ-032 Lane0=-524288, others 0 -> sum_out=524288, out lane0=256, others 0.
REQ-033 Hold out_ready=0 for 10 cycles in DONE with in_valid=1 and a new row:
- out and sum_out stay stable and the new row is not captured;
- after out_ready=1, in_ready=1 the next cycle.
REQ-034 Assert reset at DIV lane 3:
- next cycle IDLE, out_valid=0, in_ready=1, out=0;
- a following row of all +2 -> sum_out=16, each lane=32.

Source files
------------

// File: rtl/sfp_pkg.sv
// Shared types and default sizing for the psum-row normalizer (sfp_norm).
// Optional divider is enabled by defining SFP_NORM_DIV_EN.
package sfp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int COL_DEF     = 8;
    localparam int BW_PSUM_DEF = 20;
    localparam int FRAC_DEF    = 8;

    // Four guard bits hold the sum of up to 16 full-scale magnitudes.
    function automatic int sum_width(input int bw_psum);
        return bw_psum + 4;
    endfunction

    function automatic int quo_width(input int frac);
        return frac + 1;
    endfunction

    localparam int SUM_W_DEF = BW_PSUM_DEF + 4;
    localparam int QUO_W_DEF = FRAC_DEF + 1;

endpackage

// File: rtl/sfp_norm_if.sv
// Row-in / result-out handshake bundle for sfp_norm (SFP_NORM_DIV_EN selects the divider build).
interface sfp_norm_if #(
    parameter int col     = sfp_pkg::COL_DEF,
    parameter int bw_psum = sfp_pkg::BW_PSUM_DEF
);
    import sfp_pkg::*;

    localparam int sw = sum_width(bw_psum);

    logic [bw_psum*col-1:0] in;
    logic                   in_valid;
    logic                   in_ready;
    logic [bw_psum*col-1:0] out;
    logic [sw-1:0]          sum_out;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output in, in_valid, out_ready,
        input  in_ready, out, sum_out, out_valid
    );

    modport slave (
        input  in, in_valid, out_ready,
        output in_ready, out, sum_out, out_valid
    );

endinterface

// File: rtl/sfp_div_seq.sv
// Restoring divider, one quotient bit per cycle, MSB first; the start cycle already
// performs the first step so a full quotient takes exactly frac+1 cycles.
module sfp_div_seq
    import sfp_pkg::*;
#(
    parameter int dw   = BW_PSUM_DEF,
    parameter int frac = FRAC_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [dw-1:0] dividend,
    input  logic [dw+3:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [frac:0] quotient
);
    localparam int sw = sum_width(dw);
    localparam int qw = quo_width(frac);
    localparam int rw = sw + 1;
    localparam int cw = (qw > 1) ? $clog2(qw) : 1;

    logic [rw-1:0] rem_q;
    logic [rw-1:0] rem_cur;
    logic [rw-1:0] rem_sub;
    logic [qw-1:0] quo_q;
    logic [cw-1:0] cnt_q;
    logic [cw-1:0] cnt_cur;
    logic          active;
    logic          bit_cur;

    // The remainder stays below 2*divisor, so one extra bit over the sum width suffices.
    always_comb begin
        active   = start | busy;
        rem_cur  = start ? rw'(dividend) : rem_q;
        cnt_cur  = start ? '0 : cnt_q;
        bit_cur  = (divisor != '0) && (rem_cur >= rw'(divisor));
        rem_sub  = bit_cur ? (rem_cur - rw'(divisor)) : rem_cur;
        done     = active && (cnt_cur == cw'(qw - 1));
        quotient = {quo_q[qw-2:0], bit_cur};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy  <= 1'b0;
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
        end else if (active) begin
            rem_q <= rem_sub << 1;
            quo_q <= quotient;
            if (done) begin
                busy  <= 1'b0;
                cnt_q <= '0;
            end else begin
                busy  <= 1'b1;
                cnt_q <= cnt_cur + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sfp_norm.sv
// Normalizes a psum row: lane magnitudes, their sum, and (with SFP_NORM_DIV_EN defined)
// each magnitude divided by the sum as an unsigned fixed-point fraction.
module sfp_norm
    import sfp_pkg::*;
#(
    parameter int col     = COL_DEF,
    parameter int bw_psum = BW_PSUM_DEF,
    parameter int frac    = FRAC_DEF
) (
    input  logic      clk,
    input  logic      reset,
    sfp_norm_if.slave bus
);
    localparam int sw = sum_width(bw_psum);
    localparam int qw = quo_width(frac);
    localparam int lw = (col > 1) ? $clog2(col) : 1;

    state_t                 state;
    logic [bw_psum-1:0]     row      [col];
    logic [bw_psum-1:0]     mag_next [col];
    logic [sw-1:0]          sum_next;
    logic [bw_psum*col-1:0] out_next;

    // Most-negative input maps to 2^(bw_psum-1), which still fits unsigned.
    function automatic logic [bw_psum-1:0] abs_lane(input logic [bw_psum-1:0] x);
        return x[bw_psum-1] ? ('0 - x) : x;
    endfunction

    // NOTE: blocking assignments in always_comb so sum_next accumulates within one pass.
    always_comb begin
        sum_next = '0;
        for (int i = 0; i < col; i++) begin
            mag_next[i] = abs_lane(row[i]);
            sum_next    = sum_next + sw'(mag_next[i]);
        end
    end

`ifdef SFP_NORM_DIV_EN
    logic [bw_psum-1:0] mag [col];
    logic [qw-1:0]      res [col];
    logic [lw-1:0]      lane;
    logic               div_start;
    logic               div_busy;
    logic               div_done;
    logic [qw-1:0]      quo;

    assign div_start = (state == DIV) && !div_busy;

    sfp_div_seq #(
        .dw   (bw_psum),
        .frac (frac)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (mag[lane]),
        .divisor  (bus.sum_out),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quo)
    );

    // The last lane's quotient goes straight to out so DONE starts on the final step.
    always_comb begin
        out_next = '0;
        for (int i = 0; i < col; i++)
            out_next[bw_psum*i +: bw_psum] = (i == col - 1) ? bw_psum'(quo) : bw_psum'(res[i]);
    end
`else
    always_comb begin
        out_next = '0;
        for (int i = 0; i < col; i++)
            out_next[bw_psum*i +: bw_psum] = mag_next[i];
    end
`endif

    // NOTE: row/mag/res are not reset; each is rewritten before anything reads it.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.in_valid)
            for (int i = 0; i < col; i++)
                row[i] <= bus.in[bw_psum*i +: bw_psum];
`ifdef SFP_NORM_DIV_EN
        if (state == SUM)
            for (int i = 0; i < col; i++)
                mag[i] <= mag_next[i];
        if (state == DIV && div_done)
            res[lane] <= quo;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
            bus.sum_out   <= '0;
`ifdef SFP_NORM_DIV_EN
            lane          <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state        <= SUM;
                        bus.in_ready <= 1'b0;
                    end
                end
                SUM: begin
                    bus.sum_out <= sum_next;
`ifdef SFP_NORM_DIV_EN
                    state       <= DIV;
                    lane        <= '0;
`else
                    state         <= DONE;
                    bus.out       <= out_next;
                    bus.out_valid <= 1'b1;
`endif
                end
`ifdef SFP_NORM_DIV_EN
                DIV: begin
                    if (div_done) begin
                        if (lane == lw'(col - 1)) begin
                            state         <= DONE;
                            bus.out       <= out_next;
                            bus.out_valid <= 1'b1;
                        end else begin
                            lane <= lane + 1'b1;
                        end
                    end
                end
`endif
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sfp_norm.sv
// Scoreboard bench for sfp_norm; expectations follow SFP_NORM_DIV_EN (defined or not).
module tb_sfp_norm;
    import sfp_pkg::*;

    localparam int COL = 8;
    localparam int BW  = 20;
    localparam int W   = COL * BW;
    localparam int SW  = BW + 4;
`ifdef SFP_NORM_DIV_EN
    localparam int EXP_LAT = 74;
`else
    localparam int EXP_LAT = 2;
`endif

    typedef struct {
        logic [W-1:0]  out;
        logic [SW-1:0] sum;
    } exp_t;

    logic clk;
    logic reset;
    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    sfp_norm_if #(.col(COL), .bw_psum(BW)) bus ();

    sfp_norm #(.col(COL), .bw_psum(BW), .frac(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] fill(input int v);
        logic [W-1:0] f;
        for (int i = 0; i < COL; i++) f[BW*i +: BW] = BW'(v);
        return f;
    endfunction

    // Reference: plain integer arithmetic on the signed lanes.
    function automatic exp_t model(input logic [W-1:0] r);
        exp_t        e;
        longint      m [COL];
        longint      s;
        longint      q;
        logic signed [BW-1:0] v;
        s = 0;
        for (int i = 0; i < COL; i++) begin
            v    = r[BW*i +: BW];
            m[i] = (v < 0) ? -longint'(v) : longint'(v);
            s   += m[i];
        end
        e.sum = SW'(s);
        for (int i = 0; i < COL; i++) begin
`ifdef SFP_NORM_DIV_EN
            q = (s == 0) ? 0 : (m[i] * 256) / s;
`else
            q = m[i];
`endif
            e.out[BW*i +: BW] = BW'(q);
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the capture edge.
    task automatic drive_row(input string tag, input logic [W-1:0] r);
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready"}, 256'(bus.in_ready), 256'(1));
        bus.in       = r;
        bus.in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(model(r));
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // The capture edge counts as cycle 1 of the latency.
    task automatic wait_result(input string tag);
        int lat = 1;
        while (!bus.out_valid && lat < 300) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 256'(lat), 256'(EXP_LAT));
    endtask

    task automatic compare_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 256'(0), 256'(1));
        end else begin
            e = sb.pop_front();
            check({tag, "_out"}, 256'(bus.out), 256'(e.out));
            check({tag, "_sum"}, 256'(bus.sum_out), 256'(e.sum));
        end
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_rel_valid"}, 256'(bus.out_valid), 256'(0));
        check({tag, "_rel_ready"}, 256'(bus.in_ready), 256'(1));
    endtask

    task automatic run_row(input string tag, input logic [W-1:0] r);
        drive_row(tag, r);
        wait_result(tag);
        compare_pop(tag);
        release_result(tag);
    endtask

    initial begin
        logic [W-1:0] r;
        exp_t         e;
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.in        = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 256'(bus.in_ready), 256'(1));
        check("rst_out_valid", 256'(bus.out_valid), 256'(0));
        check("rst_out", 256'(bus.out), 256'(0));
        check("rst_sum", 256'(bus.sum_out), 256'(0));
        reset = 1'b0;

        run_row("ones", fill(1));
        r = '0;
        r[0 +: BW]  = BW'(-4);
        r[BW +: BW] = BW'(4);
        run_row("pm4", r);
        run_row("zero", '0);
        r = '0;
        r[0 +: BW] = BW'(-524288);
        run_row("minneg", r);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < COL; i++)
                r[BW*i +: BW] = BW'(int'($urandom_range(0, 200000)) - 100000);
            run_row($sformatf("rnd%0d", k), r);
        end

        // Stall in DONE while a new row is offered.
        r = '0;
        r[2*BW +: BW] = BW'(-7);
        r[5*BW +: BW] = BW'(21);
        drive_row("hold", r);
        wait_result("hold");
        e = sb[0];
        bus.in       = fill(-9);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("hold_out_c%0d", c), 256'(bus.out), 256'(e.out));
            check($sformatf("hold_sum_c%0d", c), 256'(bus.sum_out), 256'(e.sum));
            check($sformatf("hold_ready_c%0d", c), 256'(bus.in_ready), 256'(0));
        end
        compare_pop("hold");
        bus.in_valid = 1'b0;
        release_result("hold");
        @(posedge clk);
        @(negedge clk);
        check("hold_idle_ready", 256'(bus.in_ready), 256'(1));

        // Reset wins over a simultaneous row offer.
        reset        = 1'b1;
        bus.in       = fill(5);
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        check("rstprio_ready", 256'(bus.in_ready), 256'(1));

        // Reset in the middle of a run (lane 3 of the divide when enabled).
        drive_row("midrst", fill(3));
        repeat (29) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        void'(sb.pop_front());
        check("midrst_valid", 256'(bus.out_valid), 256'(0));
        check("midrst_ready", 256'(bus.in_ready), 256'(1));
        check("midrst_out", 256'(bus.out), 256'(0));
        run_row("after_rst", fill(2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
